// File: rtl/pc_gen_unit.sv
// Program-counter generator for the fetch stage: increment, stall, jump/call, return, redirect.
// Optional return-address stack is built when the PC_RAS_EN macro is defined.
module pc_gen_unit #(
    parameter int                ADDR_W    = 32,
    parameter int                INC       = 4,
    parameter logic [ADDR_W-1:0] RESET_VEC = '0,
    parameter int                RAS_DEPTH = 4
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              stall,
    input  logic              redirect_valid,
    input  logic [ADDR_W-1:0] redirect_addr,
    input  logic              jump_valid,
    input  logic [ADDR_W-1:0] jump_addr,
    input  logic              call,
    input  logic              ret,
    output logic [ADDR_W-1:0] pc_out,
    output logic              pc_valid,
    output logic [ADDR_W-1:0] pc_next,
    output logic              ras_empty,
    output logic              ras_full,
    output logic              ret_err,
    output logic              align_err
);

    localparam logic [ADDR_W-1:0] INC_V    = ADDR_W'(INC);
    localparam logic [ADDR_W-1:0] LOW_MASK = ADDR_W'(INC - 1);

    logic [ADDR_W-1:0] pc_q, pc_d;
    logic              pc_valid_q, pc_valid_d;
    logic              align_err_q, align_err_d;

`ifdef PC_RAS_EN
    localparam int PTR_W = $clog2(RAS_DEPTH);
    localparam int CNT_W = PTR_W + 1;

    logic [ADDR_W-1:0] ras_mem [RAS_DEPTH];
    logic [PTR_W-1:0]  sp_q, sp_d;
    logic [CNT_W-1:0]  cnt_q, cnt_d;
    logic              ras_empty_q, ras_full_q;
    logic              ret_err_q, ret_err_d;
    logic              push, pop;
    logic [ADDR_W-1:0] ras_top;

    // sp_q points at the next free slot; when full that slot holds the oldest entry.
    assign ras_top = ras_mem[sp_q - PTR_W'(1)];
`else
    logic unused_ras;
    assign unused_ras = ^{call, ret};
`endif

    assign pc_valid_d = 1'b1;

    // NOTE: every variable assigned in this block gets a default first, so no latch is inferred.
    always_comb begin
        pc_d        = pc_q + INC_V;
        align_err_d = 1'b0;
`ifdef PC_RAS_EN
        push        = 1'b0;
        pop         = 1'b0;
        ret_err_d   = 1'b0;
`endif
        if (!pc_valid_q) begin
            pc_d = pc_q;
        end else if (redirect_valid) begin
            pc_d        = redirect_addr & ~LOW_MASK;
            align_err_d = |(redirect_addr & LOW_MASK);
        end else if (stall) begin
            pc_d = pc_q;
        end else if (jump_valid) begin
            pc_d        = jump_addr & ~LOW_MASK;
            align_err_d = |(jump_addr & LOW_MASK);
`ifdef PC_RAS_EN
            push        = call;
`endif
        end
`ifdef PC_RAS_EN
        else if (ret) begin
            if (cnt_q != '0) begin
                pc_d = ras_top;
                pop  = 1'b1;
            end else begin
                ret_err_d = 1'b1;
            end
        end
`endif
    end

    assign pc_next = pc_d;

    // NOTE: sequential state uses non-blocking assignments so every flop samples pre-edge values.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            pc_q        <= RESET_VEC;
            pc_valid_q  <= 1'b0;
            align_err_q <= 1'b0;
        end else begin
            pc_q        <= pc_d;
            pc_valid_q  <= pc_valid_d;
            align_err_q <= align_err_d;
        end
    end

`ifdef PC_RAS_EN
    always_comb begin
        sp_d  = sp_q;
        cnt_d = cnt_q;
        if (push) begin
            sp_d  = sp_q + PTR_W'(1);
            cnt_d = (cnt_q == CNT_W'(RAS_DEPTH)) ? cnt_q : cnt_q + CNT_W'(1);
        end else if (pop) begin
            sp_d  = sp_q - PTR_W'(1);
            cnt_d = cnt_q - CNT_W'(1);
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            sp_q        <= '0;
            cnt_q       <= '0;
            ras_empty_q <= 1'b1;
            ras_full_q  <= 1'b0;
            ret_err_q   <= 1'b0;
        end else begin
            sp_q        <= sp_d;
            cnt_q       <= cnt_d;
            ras_empty_q <= (cnt_d == '0);
            ras_full_q  <= (cnt_d == CNT_W'(RAS_DEPTH));
            ret_err_q   <= ret_err_d;
        end
    end

    // NOTE: stack storage has no reset; the count alone decides which entries are live.
    always_ff @(posedge clk) begin
        if (push) begin
            ras_mem[sp_q] <= pc_q + INC_V;
        end
    end

    assign ras_empty = ras_empty_q;
    assign ras_full  = ras_full_q;
    assign ret_err   = ret_err_q;
`else
    assign ras_empty = 1'b1;
    assign ras_full  = 1'b0;
    assign ret_err   = 1'b0;
`endif

    assign pc_out    = pc_q;
    assign pc_valid  = pc_valid_q;
    assign align_err = align_err_q;

endmodule

// File: tb/tb_pc_gen_unit.sv
// Self-checking bench for pc_gen_unit: directed scenarios plus random stimulus
// compared against a queue-based reference model of the fetch-address rules.
module tb_pc_gen_unit;

`ifdef PC_RAS_EN
    localparam bit RAS_EN = 1'b1;
`else
    localparam bit RAS_EN = 1'b0;
`endif
    localparam int          DEPTH = 4;
    localparam logic [31:0] RVEC  = 32'h100;

    logic        clk = 1'b0;
    logic        rst = 1'b1;
    logic        stall = 1'b0, redirect_valid = 1'b0, jump_valid = 1'b0;
    logic        call = 1'b0, ret = 1'b0;
    logic [31:0] redirect_addr = '0, jump_addr = '0;
    logic [31:0] pc_out, pc_next;
    logic        pc_valid, ras_empty, ras_full, ret_err, align_err;

    pc_gen_unit #(.ADDR_W(32), .INC(4), .RESET_VEC(RVEC), .RAS_DEPTH(DEPTH)) dut (
        .clk(clk), .rst(rst), .stall(stall),
        .redirect_valid(redirect_valid), .redirect_addr(redirect_addr),
        .jump_valid(jump_valid), .jump_addr(jump_addr),
        .call(call), .ret(ret),
        .pc_out(pc_out), .pc_valid(pc_valid), .pc_next(pc_next),
        .ras_empty(ras_empty), .ras_full(ras_full),
        .ret_err(ret_err), .align_err(align_err)
    );

    always #5 clk = ~clk;

    int n_tests = 0;
    int n_fail  = 0;

    // Reference model state
    logic [31:0] m_pc;
    bit          m_valid, m_ret_err, m_align_err;
    logic [31:0] m_ras[$];

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_tests++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got 0x%08h expected 0x%08h at %0t", tag, got, exp, $time);
        end
    endtask

    task automatic check_outputs(input string tag);
        check({tag, ".pc_out"},    pc_out,    m_pc);
        check({tag, ".pc_valid"},  {31'b0, pc_valid},  {31'b0, m_valid});
        check({tag, ".ras_empty"}, {31'b0, ras_empty}, {31'b0, m_ras.size() == 0});
        check({tag, ".ras_full"},  {31'b0, ras_full},  {31'b0, m_ras.size() == DEPTH});
        check({tag, ".ret_err"},   {31'b0, ret_err},   {31'b0, m_ret_err});
        check({tag, ".align_err"}, {31'b0, align_err}, {31'b0, m_align_err});
    endtask

    task automatic model_reset();
        m_pc = RVEC; m_valid = 1'b0; m_ret_err = 1'b0; m_align_err = 1'b0;
        m_ras.delete();
    endtask

    // Called just after a falling edge; leaves the bench on the next falling edge.
    task automatic cyc(input string tag, input logic st, input logic rv, input logic [31:0] ra,
                       input logic jv, input logic [31:0] ja, input logic cl, input logic rt);
        logic [31:0] nxt;
        bit push, pop, rerr, aerr;
        stall = st; redirect_valid = rv; redirect_addr = ra;
        jump_valid = jv; jump_addr = ja; call = cl; ret = rt;
        push = 0; pop = 0; rerr = 0; aerr = 0;
        nxt = m_pc + 32'd4;
        if (!m_valid) nxt = m_pc;
        else if (rv) begin nxt = {ra[31:2], 2'b00}; aerr = (ra[1:0] != 0); end
        else if (st) nxt = m_pc;
        else if (jv) begin nxt = {ja[31:2], 2'b00}; aerr = (ja[1:0] != 0); push = cl && RAS_EN; end
        else if (rt && RAS_EN) begin
            if (m_ras.size() > 0) begin nxt = m_ras[$]; pop = 1; end
            else rerr = 1;
        end
        #1;
        check({tag, ".pc_next"}, pc_next, nxt);
        @(posedge clk);
        if (push) begin
            if (m_ras.size() == DEPTH) void'(m_ras.pop_front());
            m_ras.push_back(m_pc + 32'd4);
        end
        if (pop) void'(m_ras.pop_back());
        m_pc = nxt; m_valid = 1'b1; m_ret_err = rerr; m_align_err = aerr;
        @(negedge clk);
        check_outputs(tag);
    endtask

    task automatic idle(input string tag);
        cyc(tag, 0, 0, 0, 0, 0, 0, 0);
    endtask

    task automatic redirect(input string tag, input logic [31:0] a);
        cyc(tag, 0, 1, a, 0, 0, 0, 0);
    endtask

    task automatic do_reset(input string tag);
        @(negedge clk);
        {stall, redirect_valid, jump_valid, call, ret} = '0;
        rst = 1'b1;
        model_reset();
        #1;
        check_outputs({tag, ".in_reset"});
        @(negedge clk);
        rst = 1'b0;
    endtask

    initial begin
        model_reset();

        // Reset release and first idle edges
        do_reset("rst");
        check("rst.pc_out_c", pc_out, 32'h100);
        idle("t1a"); check("t1a.valid_c", {31'b0, pc_valid}, 32'd1); check("t1a.pc_c", pc_out, 32'h100);
        idle("t1b"); check("t1b.pc_c", pc_out, 32'h104);
        idle("t1c"); check("t1c.pc_c", pc_out, 32'h108);

        // Redirect beats stall, misaligned target
        cyc("t2", 1, 1, 32'h2002, 0, 0, 0, 0);
        check("t2.pc_c", pc_out, 32'h2000);
        check("t2.align_c", {31'b0, align_err}, 32'd1);
        idle("t2.pulse_end");

        // Call, run, return
        redirect("t3.setup", 32'h200);
        cyc("t3.call", 0, 0, 0, 1, 32'h800, 1, 0);
        check("t3.call_c", pc_out, 32'h800);
        idle("t3.i1"); idle("t3.i2");
        check("t3.i2_c", pc_out, 32'h808);
        cyc("t3.ret", 0, 0, 0, 0, 0, 0, 1);
        check("t3.ret_c", pc_out, RAS_EN ? 32'h204 : 32'h80C);

        // Overflowing the stack, then draining past empty
        for (int i = 1; i <= 5; i++) begin
            redirect("t4.setup", 32'(i * 16));
            cyc("t4.call", 0, 0, 0, 1, 32'h4000, 1, 0);
        end
        for (int i = 0; i < 5; i++) cyc("t4.ret", 0, 0, 0, 0, 0, 0, 1);
        if (RAS_EN) check("t4.last_c", pc_out, 32'h28);
        idle("t4.pulse_end");

        // Address wrap; jump beats ret
        redirect("t5.setup", 32'hFFFF_FFFC);
        idle("t5.wrap");
        check("t5.wrap_c", pc_out, 32'h0);
        cyc("t5.call", 0, 0, 0, 1, 32'h300, 1, 0);
        cyc("t5.jr", 0, 0, 0, 1, 32'h500, 0, 1);
        check("t5.jr_c", pc_out, 32'h500);

        // Asynchronous reset mid-sequence
        cyc("t6.call", 0, 0, 0, 1, 32'h900, 1, 0);
        jump_valid = 1'b1; jump_addr = 32'h777; call = 1'b1;
        #2;
        rst = 1'b1;
        model_reset();
        #1;
        check_outputs("t6.async");
        @(negedge clk);
        {stall, redirect_valid, jump_valid, call, ret} = '0;
        rst = 1'b0;
        idle("t6.first");

        // Random traffic
        for (int n = 0; n < 400; n++) begin
            logic [31:0] a;
            a = ($urandom_range(0, 7) == 0) ? (32'hFFFF_FFF0 | $urandom_range(0, 15)) : $urandom;
            cyc("rnd",
                $urandom_range(0, 7) == 0,
                $urandom_range(0, 11) == 0, a,
                $urandom_range(0, 3) == 0, $urandom,
                1'($urandom_range(0, 1)),
                $urandom_range(0, 2) == 0);
        end

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
